// File: rtl/cga_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cga_mac_seq
//  Purpose  : Sequencer/arbiter in front of the memory address calculation
//             datapath (address adder, LCA register, NLCA incrementer).
//             Grants one of three requesters (fetch, operand, refresh/scrub)
//             at a time, drives the adder/mux selects and the memory
//             request, runs a second word at NLCA for double-word operands
//             and freezes the address path while memory is busy.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    MCLK      in   system clock, rising edge
//    RESET     in   synchronous reset, active-high
//    IF_REQ    in   fetch request (level)
//    IF_ACK    out  fetch transfer accepted (1-cycle pulse)
//    OP_REQ    in   operand request (level)
//    OP_MODE   in   operand addressing mode, sampled at grant
//    OP_DOUBLE in   double-word operand, sampled at grant
//    OP_ACK    out  operand transfer accepted (1-cycle pulse)
//    RF_REQ    in   refresh/scrub request (level)
//    RF_ACK    out  refresh accepted (1-cycle pulse)
//    MEM_BUSY  in   memory cannot accept a request this cycle
//    MREQ      out  memory request, address valid
//    MSRC      out  requester owning MREQ: 01 IF, 10 OP, 11 RF, 00 none
//    PSEL      out  adder source = P register
//    CDSEL     out  adder source = CD bus
//    ADDSEL    out  adder source = ADD result
//    PB        out  add B register
//    PX        out  add X register
//    NLCASEL   out  address = LCA+1 (second word)
//    HOLD      out  freeze LCA/address registers
// ============================================================================
module cga_mac_seq #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       IF_REQ,
    output logic       IF_ACK,
    input  logic       OP_REQ,
    input  logic [1:0] OP_MODE,
    input  logic       OP_DOUBLE,
    output logic       OP_ACK,
    input  logic       RF_REQ,
    output logic       RF_ACK,
    input  logic       MEM_BUSY,
    output logic       MREQ,
    output logic [1:0] MSRC,
    output logic       PSEL,
    output logic       CDSEL,
    output logic       ADDSEL,
    output logic       PB,
    output logic       PX,
    output logic       NLCASEL,
    output logic       HOLD
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ISSUE  = 3'd1;
    localparam logic [2:0] c_WAIT   = 3'd2;
    localparam logic [2:0] c_SECOND = 3'd3;
    localparam logic [2:0] c_SWAIT  = 3'd4;

    localparam logic [1:0] c_SRC_NONE = 2'b00;
    localparam logic [1:0] c_SRC_IF   = 2'b01;
    localparam logic [1:0] c_SRC_OP   = 2'b10;
    localparam logic [1:0] c_SRC_RF   = 2'b11;

    localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    logic [2:0]       r_state;
    logic [1:0]       r_src;
    logic [1:0]       r_mode;
    logic             r_double;
    logic [CNT_W-1:0] r_starveCnt;

    logic [2:0]       w_nextState;
    logic [1:0]       w_grantSrc;
    logic             w_grantValid;
    logic [CNT_W-1:0] w_starveNext;

    // Arbitration: RF > OP > IF, except that a fetch which has lost
    // STARVE_MAX arbitrations in a row beats everyone.
    always_comb begin
        w_grantSrc = c_SRC_NONE;
        if (IF_REQ && (r_starveCnt == c_STARVE_MAX)) begin
            w_grantSrc = c_SRC_IF;
        end else if (RF_REQ) begin
            w_grantSrc = c_SRC_RF;
        end else if (OP_REQ) begin
            w_grantSrc = c_SRC_OP;
        end else if (IF_REQ) begin
            w_grantSrc = c_SRC_IF;
        end
        w_grantValid = (r_state == c_IDLE) && (w_grantSrc != c_SRC_NONE);
    end

    // Starvation counter only moves on an actual grant; it counts grants
    // that went elsewhere while a fetch was waiting.
    always_comb begin
        w_starveNext = r_starveCnt;
        if (w_grantValid) begin
            if (IF_REQ && (w_grantSrc != c_SRC_IF)) begin
                if (r_starveCnt != c_STARVE_MAX) begin
                    w_starveNext = r_starveCnt + c_CNT_ONE;
                end
            end else begin
                w_starveNext = '0;
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_state     <= c_IDLE;
            r_src       <= c_SRC_NONE;
            r_mode      <= 2'b00;
            r_double    <= 1'b0;
            r_starveCnt <= '0;
        end else begin
            r_state     <= w_nextState;
            r_starveCnt <= w_starveNext;
            if (w_grantValid) begin
                r_src <= w_grantSrc;
                // Mode/double only mean something for operand transfers.
                if (w_grantSrc == c_SRC_OP) begin
                    r_mode   <= OP_MODE;
                    r_double <= OP_DOUBLE;
                end else begin
                    r_mode   <= 2'b00;
                    r_double <= 1'b0;
                end
            end
        end
    end

    // Next state and outputs. Everything is forced low while RESET is
    // asserted so that a transfer abandoned by reset never acknowledges.
    always_comb begin
        w_nextState = r_state;
        IF_ACK      = 1'b0;
        OP_ACK      = 1'b0;
        RF_ACK      = 1'b0;
        MREQ        = 1'b0;
        MSRC        = c_SRC_NONE;
        PSEL        = 1'b0;
        CDSEL       = 1'b0;
        ADDSEL      = 1'b0;
        PB          = 1'b0;
        PX          = 1'b0;
        NLCASEL     = 1'b0;
        HOLD        = 1'b0;
        if (!RESET) begin
            case (r_state)
                c_IDLE: begin
                    if (w_grantValid) begin
                        w_nextState = c_ISSUE;
                    end
                end
                c_ISSUE, c_WAIT: begin
                    MREQ = 1'b1;
                    MSRC = r_src;
                    case (r_src)
                        c_SRC_IF: PSEL = 1'b1;
                        c_SRC_OP: begin
                            case (r_mode)
                                2'b00: CDSEL = 1'b1;
                                2'b01: begin
                                    ADDSEL = 1'b1;
                                    PB     = 1'b1;
                                end
                                2'b10: begin
                                    ADDSEL = 1'b1;
                                    PX     = 1'b1;
                                end
                                default: begin
                                    ADDSEL = 1'b1;
                                    PB     = 1'b1;
                                    PX     = 1'b1;
                                end
                            endcase
                        end
                        default: ;
                    endcase
                    if (MEM_BUSY) begin
                        HOLD        = 1'b1;
                        w_nextState = c_WAIT;
                    end else if ((r_src == c_SRC_OP) && r_double) begin
                        // First word accepted; the ACK waits for the NLCA word.
                        w_nextState = c_SECOND;
                    end else begin
                        IF_ACK      = (r_src == c_SRC_IF);
                        OP_ACK      = (r_src == c_SRC_OP);
                        RF_ACK      = (r_src == c_SRC_RF);
                        w_nextState = c_IDLE;
                    end
                end
                c_SECOND, c_SWAIT: begin
                    MREQ    = 1'b1;
                    MSRC    = c_SRC_OP;
                    NLCASEL = 1'b1;
                    if (MEM_BUSY) begin
                        HOLD        = 1'b1;
                        w_nextState = c_SWAIT;
                    end else begin
                        OP_ACK      = 1'b1;
                        w_nextState = c_IDLE;
                    end
                end
                default: w_nextState = c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cga_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cga_mac_seq
//  Purpose  : Self-checking bench for cga_mac_seq. A transaction-level model
//             (current owner + words remaining) predicts every output each
//             cycle; directed sequences cover reset abort, mode decode,
//             double-word with busy, starvation and back-to-back fetch,
//             followed by random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cga_mac_seq;

    localparam int STARVE_MAX = 4;

    logic       MCLK = 1'b0;
    logic       RESET;
    logic       IF_REQ, OP_REQ, RF_REQ, OP_DOUBLE, MEM_BUSY;
    logic [1:0] OP_MODE;
    logic       IF_ACK, OP_ACK, RF_ACK, MREQ, PSEL, CDSEL, ADDSEL, PB, PX, NLCASEL, HOLD;
    logic [1:0] MSRC;

    int total = 0;
    int bad   = 0;

    // Reference model state: owner 0 none / 1 IF / 2 OP / 3 RF
    int         mSrc  = 0;
    int         mWord = 1;
    int         mCnt  = 0;
    logic [1:0] mMode = 2'b00;
    bit         mDouble = 1'b0;
    int         ackQ[$];

    cga_mac_seq #(.STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
        .MCLK(MCLK), .RESET(RESET),
        .IF_REQ(IF_REQ), .IF_ACK(IF_ACK),
        .OP_REQ(OP_REQ), .OP_MODE(OP_MODE), .OP_DOUBLE(OP_DOUBLE), .OP_ACK(OP_ACK),
        .RF_REQ(RF_REQ), .RF_ACK(RF_ACK),
        .MEM_BUSY(MEM_BUSY),
        .MREQ(MREQ), .MSRC(MSRC),
        .PSEL(PSEL), .CDSEL(CDSEL), .ADDSEL(ADDSEL), .PB(PB), .PX(PX),
        .NLCASEL(NLCASEL), .HOLD(HOLD)
    );

    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, let them settle,
    // compare the outputs against the model, then advance the model.
    task automatic step(input bit rst, input bit ifr, input bit opr, input bit rfr,
                        input logic [1:0] mode, input bit dbl, input bit busy);
        logic [12:0] got, exp;
        bit eIfA, eOpA, eRfA, eMreq, ePsel, eCd, eAdd, ePb, ePx, eNl, eHold;
        logic [1:0] eMsrc;
        int g;
        @(negedge MCLK);
        RESET = rst; IF_REQ = ifr; OP_REQ = opr; RF_REQ = rfr;
        OP_MODE = mode; OP_DOUBLE = dbl; MEM_BUSY = busy;
        #1;
        {eIfA, eOpA, eRfA, eMreq, ePsel, eCd, eAdd, ePb, ePx, eNl, eHold} = '0;
        eMsrc = 2'b00;
        if (rst) begin
            mSrc = 0;
            mCnt = 0;
        end else if (mSrc == 0) begin
            if (ifr || opr || rfr) begin
                if (ifr && mCnt == STARVE_MAX) g = 1;
                else if (rfr)                  g = 3;
                else if (opr)                  g = 2;
                else                           g = 1;
                if (ifr && g != 1) mCnt = (mCnt + 1 > STARVE_MAX) ? STARVE_MAX : mCnt + 1;
                else               mCnt = 0;
                mSrc    = g;
                mWord   = 1;
                mMode   = mode;
                mDouble = (g == 2) && dbl;
            end
        end else begin
            eMreq = 1'b1;
            eHold = busy;
            if (mWord == 1) begin
                eMsrc = 2'(mSrc);
                if (mSrc == 1) ePsel = 1'b1;
                if (mSrc == 2) begin
                    eCd  = (mMode == 2'b00);
                    eAdd = (mMode != 2'b00);
                    ePb  = (mMode == 2'b01) || (mMode == 2'b11);
                    ePx  = (mMode == 2'b10) || (mMode == 2'b11);
                end
            end else begin
                eMsrc = 2'b10;
                eNl   = 1'b1;
            end
            if (!busy) begin
                if (mWord == 1 && mDouble) begin
                    mWord = 2;
                end else begin
                    eIfA = (mSrc == 1);
                    eOpA = (mSrc == 2);
                    eRfA = (mSrc == 3);
                    mSrc = 0;
                end
            end
        end
        exp = {eIfA, eOpA, eRfA, eMreq, eMsrc, ePsel, eCd, eAdd, ePb, ePx, eNl, eHold};
        got = {IF_ACK, OP_ACK, RF_ACK, MREQ, MSRC, PSEL, CDSEL, ADDSEL, PB, PX, NLCASEL, HOLD};
        chk("outs", 32'(got), 32'(exp));
        if (IF_ACK) ackQ.push_back(1);
        if (OP_ACK) ackQ.push_back(2);
        if (RF_ACK) ackQ.push_back(3);
    endtask

    initial begin
        RESET = 1'b1; IF_REQ = 0; OP_REQ = 0; RF_REQ = 0;
        OP_MODE = 2'b00; OP_DOUBLE = 0; MEM_BUSY = 0;

        // Reset state
        step(1, 0, 0, 0, 2'b00, 0, 0);
        step(1, 0, 0, 0, 2'b00, 0, 0);
        step(0, 0, 0, 0, 2'b00, 0, 0);
        chk("idleMreq", {31'd0, MREQ}, 32'd0);

        // Reset abort during WAIT of an operand transfer
        step(0, 0, 1, 0, 2'b01, 0, 1);
        step(0, 0, 1, 0, 2'b01, 0, 1);
        step(0, 0, 1, 0, 2'b01, 0, 1);
        step(1, 0, 1, 0, 2'b01, 0, 0);
        chk("rstNoAck", {31'd0, OP_ACK}, 32'd0);
        step(1, 0, 0, 0, 2'b01, 0, 0);
        step(0, 1, 0, 0, 2'b00, 0, 0);
        chk("rstIdle", {28'd0, MREQ, MSRC, OP_ACK}, 32'd0);
        step(0, 0, 0, 0, 2'b00, 0, 0);
        chk("rstFetch", {28'd0, MREQ, MSRC, PSEL}, 32'b1011);

        // Single operand, mode B+X
        step(0, 0, 1, 0, 2'b11, 0, 0);
        step(0, 0, 0, 0, 2'b00, 0, 0);
        chk("opBX", {27'd0, MREQ, ADDSEL, PB, PX, OP_ACK}, 32'b11111);
        step(0, 0, 0, 0, 2'b00, 0, 0);
        chk("opBXidle", {31'd0, MREQ}, 32'd0);

        // Double operand, CD direct, busy for 2 cycles in SECOND
        step(0, 0, 1, 0, 2'b00, 1, 0);
        step(0, 0, 0, 0, 2'b11, 0, 0);
        chk("dblCd", {29'd0, CDSEL, NLCASEL, OP_ACK}, 32'b100);
        step(0, 0, 0, 0, 2'b11, 0, 1);
        step(0, 0, 0, 0, 2'b11, 0, 1);
        chk("dblHold", {29'd0, NLCASEL, HOLD, OP_ACK}, 32'b110);
        step(0, 0, 0, 0, 2'b11, 0, 0);
        chk("dblAck", {29'd0, NLCASEL, HOLD, OP_ACK}, 32'b101);

        // Starvation: everyone holds requests; fetch forced on 5th grant
        step(1, 0, 0, 0, 2'b00, 0, 0);
        ackQ.delete();
        for (int i = 0; i < 12; i++) step(0, 1, 1, 1, 2'b00, 0, 0);
        chk("starveN", ackQ.size(), 6);
        if (ackQ.size() == 6) begin
            chk("starve0", ackQ[0], 3);
            chk("starve3", ackQ[3], 3);
            chk("starveIf", ackQ[4], 1);
            chk("starveClr", ackQ[5], 3);
        end

        // Fetch drops REQ after grant, memory busy 3 cycles
        step(1, 0, 0, 0, 2'b00, 0, 0);
        ackQ.delete();
        step(0, 1, 0, 0, 2'b00, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2'b00, 0, 1);
        step(0, 0, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2'b00, 0, 0);
        chk("dropAcks", ackQ.size(), 1);

        // Back-to-back fetch
        ackQ.delete();
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 2'b00, 0, 0);
        chk("b2bAcks", ackQ.size(), 4);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) == 0),
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cga_mac_seq.md
Name: cga_mac_seq

Overview:
- Sequencer and arbiter in front of the memory address calculation datapath (address adder, LCA register, NLCA incrementer).
- Three requesters share the datapath: instruction fetch, operand access and refresh/ECC scrub.
- Grants one requester at a time and drives the adder/mux select lines and the memory request.
- Runs a second transfer at NLCA for double-word operands; holds the datapath while memory is busy.

Parameters:
STARVE_MAX, 4, consecutive lost arbitrations after which fetch is forced to win (1..7)
CNT_W, 3, starvation counter width; must hold STARVE_MAX

Ports:
MCLK  in  1  system clock, all state changes on rising edge
RESET  in  1  synchronous reset, active-high
IF_REQ  in  1  fetch request, level, held until IF_ACK
IF_ACK  out  1  one-cycle pulse, fetch transfer accepted
OP_REQ  in  1  operand request, level, held until OP_ACK
OP_MODE  in  2  00 CD direct, 01 B-rel, 10 X-rel, 11 B+X; sampled at grant
OP_DOUBLE  in  1  double-word operand; sampled at grant
OP_ACK  out  1  one-cycle pulse, operand transfer (both words if double) accepted
RF_REQ  in  1  refresh/scrub request, level
RF_ACK  out  1  one-cycle pulse, refresh accepted
MEM_BUSY  in  1  memory cannot accept request this cycle
MREQ  out  1  memory request, address valid
MSRC  out  2  source of MREQ: 01 fetch, 10 operand, 11 refresh, 00 none
PSEL  out  1  adder source = P register
CDSEL  out  1  adder source = CD bus
ADDSEL  out  1  adder source = ADD result
PB  out  1  add B register
PX  out  1  add X register
NLCASEL  out  1  address = LCA+1 (second word)
HOLD  out  1  freeze LCA/address registers

Behaviour:
- Reset: all outputs 0, state IDLE, starvation counter 0. RESET overrides everything, including mid-transfer: the transfer is abandoned and no ACK is issued.
- States: IDLE, ISSUE, WAIT, SECOND, SWAIT.
- IDLE arbitration: priority RF > OP > IF. IF wins over both when counter == STARVE_MAX. With no request, stay IDLE with all outputs 0.
- On grant: latch source, OP_MODE and OP_DOUBLE (OP only); go to ISSUE next cycle. Minimum latency REQ to MREQ is 1 cycle.
- ISSUE/WAIT outputs:
  - MREQ=1 and MSRC=source.
  - Fetch: PSEL=1.
  - OP mode 00: CDSEL=1. Mode 01: ADDSEL,PB. Mode 10: ADDSEL,PX. Mode 11: ADDSEL,PB,PX.
  - Refresh: no select lines.
- ISSUE/WAIT transitions:
  - MEM_BUSY=1: go to/stay in WAIT, HOLD=1, outputs unchanged.
  - MEM_BUSY=0 and not double: pulse the source ACK this cycle, then go to IDLE.
  - MEM_BUSY=0 and double: no ACK; go to SECOND.
- SECOND/SWAIT outputs: MREQ=1, MSRC=10, NLCASEL=1, all other selects 0.
- SECOND/SWAIT transitions: MEM_BUSY=1 goes to SWAIT with HOLD=1. MEM_BUSY=0 pulses OP_ACK, then IDLE.
- Throughput: one single transfer per 2 cycles when MEM_BUSY=0; a double takes 3 cycles.
- Requester dropping REQ after grant: the transfer still completes and the ACK still pulses. Requests are not re-sampled until IDLE.
- The ACKed requester still holding REQ in the IDLE cycle after its ACK is treated as a new request.
- Starvation counter, updated at each IDLE grant:
  - IF_REQ=1 and OP or RF granted: increment, saturating at STARVE_MAX.
  - IF granted, or IF_REQ=0: clear to 0.
- Simultaneous RF+OP+IF with counter < STARVE_MAX: RF granted.
- OP_MODE/OP_DOUBLE changing mid-transfer: no effect, latched values are used.

Test Plan:
- RESET high 2 cycles during WAIT of an OP transfer -> next cycle all outputs 0, no OP_ACK; IF_REQ=1 next -> MREQ=1, MSRC=01, PSEL=1 one cycle later.
- OP_REQ=1, OP_MODE=11, OP_DOUBLE=0, MEM_BUSY=0 -> cycle 1: MREQ,ADDSEL,PB,PX=1, OP_ACK=1; cycle 2: IDLE, MREQ=0.
- OP_DOUBLE=1, OP_MODE=00, MEM_BUSY=1 for 2 cycles in SECOND -> ISSUE (CDSEL) 1 cycle, then 3 cycles NLCASEL=1 with HOLD=1 on cycles 1-2, OP_ACK only in final cycle.
- RF_REQ, OP_REQ, IF_REQ all held high, RF/OP re-requesting after each ACK -> grant order RF,RF,RF,RF, then IF on 5th arbitration (STARVE_MAX=4), counter back to 0.
- IF_REQ dropped the cycle after grant, MEM_BUSY=1 for 3 cycles -> MREQ/PSEL/HOLD held 3 cycles, IF_ACK pulses in 4th, no second fetch.
- Back-to-back IF_REQ continuously high, MEM_BUSY=0 -> MREQ pattern 0,1,0,1,... with IF_ACK coincident with each MREQ.
